// File: rtl/dram_pkg.sv
// Shared constants and types for the data-RAM arbiter and its address decoders.
package dram_pkg;

  localparam logic [31:0] DRAM_BASE  = 32'h6800_0000;
  localparam logic [31:0] DRAM_LAST  = 32'h6800_03FC;
  localparam int unsigned DRAM_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dram_req_t;

endpackage

// File: rtl/dram_addr_chk.sv
// Combinational window/alignment check; bad when addr is outside [BASE, LAST] or not word aligned.
module dram_addr_chk #(
  parameter logic [31:0] BASE = 32'h6800_0000,
  parameter logic [31:0] LAST = 32'h6800_03FC
) (
  input  logic [31:0] addr,
  output logic        bad
);

  assign bad = (addr < BASE) | (addr > LAST) | (addr[1:0] != 2'b00);

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data RAM, one access per 3 cycles.
// Define DRAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dram_arbiter
  import dram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DRAM_BASE,
  parameter logic [31:0] LAST_ADDR = DRAM_LAST,
  parameter int unsigned IDX_W     = $clog2(DRAM_WORDS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_we,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  localparam logic [31:0] MAX_OFFS = 32'(((64'd1 << IDX_W) - 64'd1) << 2);

  arb_state_t  state;
  dram_req_t   req_q;
  dram_req_t   sel_req;
  logic        owner_q;
  logic        bad_q;
  logic        any_req;
  logic        win1;
  logic        chk_bad;
  logic        sel_bad;
  logic [31:0] offs;
  logic [31:0] rsp_data;

  assign any_req = m0_req | m1_req;

`ifdef DRAM_ARB_RR_EN
  logic prio_q;
  assign win1 = m1_req & (~m0_req | prio_q);
`else
  assign win1 = ~m0_req;
`endif

  always_comb begin
    sel_req       = '0;
    sel_req.we    = win1 ? m1_we    : m0_we;
    sel_req.addr  = win1 ? m1_addr  : m0_addr;
    sel_req.wdata = win1 ? m1_wdata : m0_wdata;
  end

  dram_addr_chk #(
    .BASE (BASE_ADDR),
    .LAST (LAST_ADDR)
  ) u_addr_chk (
    .addr (sel_req.addr),
    .bad  (chk_bad)
  );

  // Also reject anything beyond the word-index range of the RAM instance.
  assign offs    = sel_req.addr - BASE_ADDR;
  assign sel_bad = chk_bad | (offs > MAX_OFFS);

  assign m0_gnt = (state == IDLE) & m0_req & ~win1;
  assign m1_gnt = (state == IDLE) & m1_req & win1;

  assign ram_a    = req_q.addr;
  assign ram_wd   = req_q.wdata;
  assign ram_we   = (state == ACCESS) & req_q.we & ~bad_q & ~RST;
  assign rsp_data = (bad_q | req_q.we) ? 32'h0 : ram_rd;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      req_q     <= '0;
      owner_q   <= 1'b0;
      bad_q     <= 1'b0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
`ifdef DRAM_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            req_q   <= sel_req;
            owner_q <= win1;
            bad_q   <= sel_bad;
            state   <= ACCESS;
`ifdef DRAM_ARB_RR_EN
            prio_q  <= ~win1;
`endif
          end
        end
        ACCESS: begin
          // Response registers load here so rvalid/rdata/err appear together in RESP.
          m0_rvalid <= ~owner_q;
          m0_rdata  <= owner_q ? 32'h0 : rsp_data;
          m0_err    <= ~owner_q & bad_q;
          m1_rvalid <= owner_q;
          m1_rdata  <= owner_q ? rsp_data : 32'h0;
          m1_err    <= owner_q & bad_q;
          state     <= RESP;
        end
        RESP: begin
          m0_rvalid <= 1'b0;
          m0_rdata  <= '0;
          m0_err    <= 1'b0;
          m1_rvalid <= 1'b0;
          m1_rdata  <= '0;
          m1_err    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural 256-word RAM on the ram_* port.
module tb_dram_arbiter;

  logic        CLK;
  logic        RST;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_a, ram_wd, ram_rd;

  logic [31:0] mem [0:255];
  int checks;
  int errors;

  dram_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .ram_we    (ram_we),
    .ram_a     (ram_a),
    .ram_wd    (ram_wd),
    .ram_rd    (ram_rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ram_rd = mem[ram_a[9:2]];
  always @(posedge CLK) if (ram_we === 1'b1) mem[ram_a[9:2]] <= ram_wd;

  // Drives one request, returns the response and the observed cycle timing.
  task automatic do_access(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                           output int gnt_wait, output int rv_lat, output int we_cycles,
                           output logic other_rv);
    gnt_wait = -1; rv_lat = -1; we_cycles = 0; other_rv = 1'b0; rd = '0; er = 1'b0;
    if (!port) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if ((port ? m1_gnt : m0_gnt) === 1'b1) begin
        gnt_wait = c;
        if (ram_we === 1'b1) we_cycles++;
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 32'hFFFF_FFFF; m1_addr = 32'hFFFF_FFFF;
    m0_wdata = 32'hBAD0_BAD0; m1_wdata = 32'hBAD0_BAD0;
    if (gnt_wait < 0) return;
    for (int c = 1; c < 10; c++) begin
      @(negedge CLK);
      if (ram_we === 1'b1) we_cycles++;
      if ((port ? m0_rvalid : m1_rvalid) !== 1'b0) other_rv = 1'b1;
      if ((port ? m1_rvalid : m0_rvalid) === 1'b1) begin
        rv_lat = c;
        rd = port ? m1_rdata : m0_rdata;
        er = port ? m1_err : m0_err;
        break;
      end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    checks++; if ({m0_err, m1_err} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {m0_err, m1_err}); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", m0_rdata, m1_rdata); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    checks++; if (ram_a !== 32'h0) begin errors++; $display("FAIL reset_ram_a got %h exp 0", ram_a); end
    checks++; if (ram_wd !== 32'h0) begin errors++; $display("FAIL reset_ram_wd got %h exp 0", ram_wd); end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_p0_write_read;
    logic [31:0] rd; logic er, orv; int gw, lat, wc;
    do_access(1'b0, 1'b1, 32'h6800_0010, 32'hDEAD_BEEF, rd, er, gw, lat, wc, orv);
    checks++; if (gw !== 0) begin errors++; $display("FAIL wr_gnt_wait got %0d exp 0", gw); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL wr_ram_we_cycles got %0d exp 1", wc); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_rvalid_lat got %0d exp 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr_resp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    checks++; if (orv !== 1'b0) begin errors++; $display("FAIL wr_other_rvalid got %b exp 0", orv); end
    checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ram_word got %h exp deadbeef", mem[4]); end
    do_access(1'b0, 1'b0, 32'h6800_0010, 32'h0, rd, er, gw, lat, wc, orv);
    checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin errors++; $display("FAIL rd_after_wr got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); end
    checks++; if (wc !== 0 || lat !== 2) begin errors++; $display("FAIL rd_timing got we_cycles=%0d lat=%0d exp 0/2", wc, lat); end
  endtask

  task automatic test_simultaneous;
    int gcyc [4]; int gport [4]; int ng; logic both; int exp_port;
    ng = 0; both = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h6800_0000; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h6800_0004; m1_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (m0_gnt === 1'b1 && m1_gnt === 1'b1) both = 1'b1;
      if ((m0_gnt === 1'b1 || m1_gnt === 1'b1) && ng < 4) begin
        gcyc[ng] = c; gport[ng] = (m1_gnt === 1'b1) ? 1 : 0; ng++;
      end
      @(posedge CLK); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (ng !== 4) begin errors++; $display("FAIL sim_grant_count got %0d exp 4", ng); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL sim_double_grant got %b exp 0", both); end
    for (int k = 0; k < ng; k++) begin
`ifdef DRAM_ARB_RR_EN
      exp_port = k % 2;
`else
      exp_port = 0;
`endif
      checks++; if (gcyc[k] !== 3 * k) begin errors++; $display("FAIL sim_grant_cycle[%0d] got %0d exp %0d", k, gcyc[k], 3 * k); end
      checks++; if (gport[k] !== exp_port) begin errors++; $display("FAIL sim_grant_port[%0d] got %0d exp %0d", k, gport[k], exp_port); end
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er, orv; int gw, lat, wc;
    do_access(1'b1, 1'b1, 32'h6800_0400, 32'h5555_AAAA, rd, er, gw, lat, wc, orv);
    checks++; if (gw !== 0 || lat !== 2) begin errors++; $display("FAIL oor_timing got gnt_wait=%0d lat=%0d exp 0/2", gw, lat); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL oor_ram_we got %0d cycles exp 0", wc); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_resp got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    checks++; if (orv !== 1'b0) begin errors++; $display("FAIL oor_other_rvalid got %b exp 0", orv); end
    checks++; if (mem[0] !== 32'hC0DE_0000) begin errors++; $display("FAIL oor_ram_word got %h exp c0de0000", mem[0]); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic er, orv; int gw, lat, wc;
    do_access(1'b0, 1'b0, 32'h6800_0002, 32'h0, rd, er, gw, lat, wc, orv);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL misaligned_lat got %0d exp 2", lat); end
  endtask

  task automatic test_boundaries;
    logic [31:0] rd; logic er, orv; int gw, lat, wc;
    do_access(1'b0, 1'b0, 32'h6800_03FC, 32'h0, rd, er, gw, lat, wc, orv);
    checks++; if (er !== 1'b0 || rd !== 32'hC0DE_00FF) begin errors++; $display("FAIL last_word got err=%b rdata=%h exp err=0 rdata=c0de00ff", er, rd); end
    do_access(1'b1, 1'b0, 32'h67FF_FFFC, 32'h0, rd, er, gw, lat, wc, orv);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL below_base got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL below_base_lat got %0d exp 2", lat); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd; logic er, orv, gnt_seen, rv_seen, we_seen; int gw, lat, wc;
    rv_seen = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h6800_0020; m0_wdata = 32'h1234_5678;
    @(negedge CLK);
    gnt_seen = m0_gnt;
    @(posedge CLK); #1;
    m0_req = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    we_seen = ram_we;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) rv_seen = 1'b1;
    end
    @(posedge CLK); #1;
    checks++; if (gnt_seen !== 1'b1) begin errors++; $display("FAIL rst_wr_gnt got %b exp 1", gnt_seen); end
    checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL rst_wr_ram_we got %b exp 0", we_seen); end
    checks++; if (rv_seen !== 1'b0) begin errors++; $display("FAIL rst_wr_rvalid got %b exp 0", rv_seen); end
    do_access(1'b0, 1'b0, 32'h6800_0020, 32'h0, rd, er, gw, lat, wc, orv);
    checks++; if (gw !== 0) begin errors++; $display("FAIL rst_idle_gnt_wait got %0d exp 0", gw); end
    checks++; if (rd !== 32'hC0DE_0008 || er !== 1'b0) begin errors++; $display("FAIL rst_prior_value got err=%b rdata=%h exp err=0 rdata=c0de0008", er, rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    RST = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_p0_write_read();
    test_simultaneous();
    test_out_of_range();
    test_misaligned();
    test_boundaries();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter and sequencer in front of the single-port data RAM. It shares the RAM between the core load/store unit (port 0) and the DMA/debug loader (port 1). Each access is decoded against the data-RAM window 0x6800_0000–0x6800_03FC, driven onto the RAM for exactly one cycle, and answered with a registered response. It sits between the requesters and the RAM instance: the RAM's WE/WD/A are driven only by this block, and its RD is consumed only by this block.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h6800_0000, first byte address of the window.
- `LAST_ADDR`, default 32'h6800_03FC, last word address of the window.
- `IDX_W`, default 8, word-index width (256 words).

Ports (one clock; reset is synchronous and active-high):
- `CLK` in 1: clock, all state changes on posedge.
- `RST` in 1: synchronous, active-high reset.
- `m0_req`, `m1_req` in 1: request; held until granted.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_gnt`, `m1_gnt` out 1: request accepted this cycle (combinational in IDLE).
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle response pulse.
- `m0_rdata`, `m1_rdata` out 32: read data, valid with rvalid.
- `m0_err`, `m1_err` out 1: access rejected, valid with rvalid.
- `ram_we` out 1: RAM write enable.
- `ram_a` out 32: RAM address.
- `ram_wd` out 32: RAM write data.
- `ram_rd` in 32: RAM combinational read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** if any req, pick a winner and assert its `gnt`. Latch we/addr/wdata, the owner id, and `bad` = (addr outside [BASE_ADDR, LAST_ADDR]) | (addr[1:0] != 0). Go to ACCESS. With no req, stay in IDLE.
- **ACCESS:** `ram_a` = latched addr. `ram_wd` = latched wdata. `ram_we` = latched we & ~bad & ~RST. Capture `rdata_q` = bad ? 0 : (we ? 0 : ram_rd). Capture `err_q` = bad. Go to RESP.
- **RESP:** owner's `rvalid` = 1, and `rdata`/`err` are driven from `rdata_q`/`err_q`. Go to IDLE.
- The non-owner's rvalid, rdata and err are 0. Both rdata buses read 0 outside RESP.
- A bad access never asserts `ram_we`. It still completes the full handshake, returning err = 1 and rdata = 0.
- Outside ACCESS, `ram_we` = 0 and `ram_a`/`ram_wd` hold their latched values.
- **Arbitration:** fixed priority, port 0 wins by default (see Configuration). Only one transaction is in flight at a time, and requests arriving in ACCESS/RESP are not granted.
- **Reset values:** state IDLE, all gnt/rvalid/err = 0, rdata = 0, `ram_we` = 0, `ram_a`/`ram_wd` = 0, round-robin pointer = port 0.
- **Reset mid-operation:** the transaction is dropped with no response. A write in ACCESS coinciding with RST is suppressed.

## Timing
- Request seen with gnt at cycle N. RAM access at N+1 (a write commits at the N+1→N+2 edge). rvalid at N+2.
- The earliest next grant is N+3, giving sustained throughput of one access per 3 cycles.
- A requester must keep req/we/addr/wdata stable until it sees gnt. It may drop req or change its fields in the cycle after gnt.
- A read after a write to the same word returns the new data, because the write commits before the next ACCESS cycle.

## Configuration
- `DRAM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit pointer holds the priority port and is set to the non-winner after every grant.
  - Simultaneous requests alternate 0, 1, 0, 1…
  - A lone requester is always granted.
- Undefined: fixed priority, port 0 always wins. Port 1 is served only when port 0 is idle, and no pointer is built.

## Structure
- Package `dram_pkg`:
  - `DRAM_BASE`, `DRAM_LAST`, `DRAM_WORDS` constants.
  - `arb_state_t` enum (IDLE, ACCESS, RESP).
  - `dram_req_t` struct {we, addr, wdata}, used for the latched request.
- Sub-module `dram_addr_chk`: combinational window and alignment check, producing `bad`, parameterised by BASE/LAST. It is reused by other bus decoders.
- The arbiter, FSM and response registers live in `dram_arbiter`.

## Test plan
- **Port 0 write then read:** port 0 writes 0x6800_0010 ← 0xDEAD_BEEF, then reads the same address. Expected: gnt at N, ram_we high only at N+1, m0_rvalid at N+2 with err = 0; the read returns 0xDEAD_BEEF, err = 0.
- **Simultaneous requests:** both ports request every cycle for 4 transactions. Fixed build: grants 0,0,0,0 and port 1 is never served. `DRAM_ARB_RR_EN` build: grants 0,1,0,1 at cycles N, N+3, N+6, N+9.
- **Out of range:** port 1 writes 0x6800_0400. Expected: ram_we stays 0, m1_rvalid = 1, err = 1, rdata = 0; RAM contents unchanged.
- **Misaligned:** port 0 reads 0x6800_0002. Expected: err = 1, rdata = 0.
- **Range boundaries:** read 0x6800_03FC → err = 0. Read 0x67FF_FFFC → err = 1.
- **Reset during ACCESS of a write:** RST asserted in the ACCESS cycle of a write of 0x1234_5678 to 0x6800_0020. Expected: ram_we = 0 in that cycle, no rvalid, state IDLE next cycle, and a later read returns the prior value.
